// File: rtl/example_02_pkg.sv
// Shared constants for the example_02 majority-pair detector.
package example_02_pkg;

  localparam int TERM_AB = 0;
  localparam int TERM_AD = 1;
  localparam int TERM_CB = 2;
  localparam int TERM_CD = 3;

  localparam int N_TERMS         = 4;
  localparam int COUNT_W_DEFAULT = 16;

endpackage

// File: rtl/example_02_core.sv
// Combinational core: f_next = (a|c)&(b|d) and the four product terms behind it.
module example_02_core
  import example_02_pkg::*;
(
  input  logic               a,
  input  logic               b,
  input  logic               c,
  input  logic               d,
  output logic               f_next,
  output logic [N_TERMS-1:0] terms_next
);

  always_comb begin
    terms_next          = '0;
    terms_next[TERM_AB] = a & b;
    terms_next[TERM_AD] = a & d;
    terms_next[TERM_CB] = c & b;
    terms_next[TERM_CD] = c & d;
  end

  // Factored form; equals the OR of the product terms above.
  assign f_next = (a | c) & (b | d);

endmodule

// File: rtl/example_02.sv
// Registered majority-pair detector with edge pulses and a saturating hit counter.
module example_02
  import example_02_pkg::*;
#(
  parameter int COUNT_W = COUNT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               a,
  input  logic               b,
  input  logic               c,
  input  logic               d,
  input  logic               cnt_clr,
  output logic               f,
  output logic [N_TERMS-1:0] terms,
  output logic               f_rise,
  output logic               f_fall,
  output logic [COUNT_W-1:0] hit_count
);

  logic               f_next;
  logic [N_TERMS-1:0] terms_next;

  logic               f_q, f_d;
  logic [N_TERMS-1:0] terms_q, terms_d;
  logic               rise_q, rise_d;
  logic               fall_q, fall_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    if (v == {COUNT_W{1'b1}}) return v;
    return v + COUNT_W'(1);
  endfunction

  example_02_core u_core (
    .a          (a),
    .b          (b),
    .c          (c),
    .d          (d),
    .f_next     (f_next),
    .terms_next (terms_next)
  );

  always_comb begin
    f_d     = f_next;
    terms_d = terms_next;
    rise_d  = f_next & ~f_q;
    fall_d  = ~f_next & f_q;
    // Clear takes priority over a hit on the same edge.
    if (cnt_clr)     cnt_d = '0;
    else if (f_next) cnt_d = sat_inc(cnt_q);
    else             cnt_d = cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q     <= 1'b0;
      terms_q <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      f_q     <= f_d;
      terms_q <= terms_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign f         = f_q;
  assign terms     = terms_q;
  assign f_rise    = rise_q;
  assign f_fall    = fall_q;
  assign hit_count = cnt_q;

endmodule

// File: tb/tb_example_02.sv
// Scoreboard bench for example_02, built with a 3-bit counter so saturation is reachable.
module tb_example_02;

  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
  logic          cnt_clr = 1'b0;
  logic          f;
  logic [3:0]    terms;
  logic          f_rise, f_fall;
  logic [CW-1:0] hit_count;

  typedef struct packed {
    logic          f;
    logic [3:0]    terms;
    logic          rise;
    logic          fall;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          sb[$];
  logic          m_f;
  logic [CW-1:0] m_cnt;
  int            n_chk = 0;
  int            n_pass = 0;

  example_02 #(.COUNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .cnt_clr   (cnt_clr),
    .f         (f),
    .terms     (terms),
    .f_rise    (f_rise),
    .f_fall    (f_fall),
    .hit_count (hit_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_f   = 1'b0;
    m_cnt = '0;
    sb.delete();
  endtask

  // Drive one input vector, push the model prediction, then compare after the edge.
  task automatic step(input string tag, input logic [3:0] abcd, input logic clr);
    exp_t e;
    logic fn;
    {a, b, c, d} = abcd;
    cnt_clr = clr;
    fn = (abcd[3] | abcd[1]) & (abcd[2] | abcd[0]);
    e.f     = fn;
    e.terms = {abcd[1] & abcd[0], abcd[1] & abcd[2], abcd[3] & abcd[0], abcd[3] & abcd[2]};
    e.rise  = fn & ~m_f;
    e.fall  = ~fn & m_f;
    if (clr)                            e.cnt = '0;
    else if (fn && m_cnt != {CW{1'b1}}) e.cnt = m_cnt + 1'b1;
    else                                e.cnt = m_cnt;
    m_f   = e.f;
    m_cnt = e.cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_f"}, 32'(f), 32'(e.f));
      check({tag, "_terms"}, 32'(terms), 32'(e.terms));
      check({tag, "_rise"}, 32'(f_rise), 32'(e.rise));
      check({tag, "_fall"}, 32'(f_fall), 32'(e.fall));
      check({tag, "_cnt"}, 32'(hit_count), 32'(e.cnt));
      check({tag, "_f_or_terms"}, 32'(f), 32'(|terms));
      check({tag, "_pulse_excl"}, 32'(f_rise & f_fall), 32'd0);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_f"}, 32'(f), 32'd0);
    check({tag, "_terms"}, 32'(terms), 32'd0);
    check({tag, "_rise"}, 32'(f_rise), 32'd0);
    check({tag, "_fall"}, 32'(f_fall), 32'd0);
    check({tag, "_cnt"}, 32'(hit_count), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    // Reset held with all inputs high across clock edges.
    {a, b, c, d} = 4'b1111;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("rst_hold");
    #2;
    rst_n = 1'b1;
    step("rst_rel", 4'b1111, 1'b0);

    // Directed vectors.
    do_reset();
    step("v0000", 4'b0000, 1'b0);
    step("v1100", 4'b1100, 1'b0);
    step("v0110", 4'b0110, 1'b0);
    step("v1001", 4'b1001, 1'b0);
    step("v1111", 4'b1111, 1'b0);
    step("v0011", 4'b0011, 1'b0);
    step("v1010", 4'b1010, 1'b0);
    step("v0101", 4'b0101, 1'b0);

    // Exhaustive sweep, forward and reverse order.
    for (int i = 0; i < 16; i++) step($sformatf("ex%0d", i), 4'(i), 1'b0);
    for (int i = 15; i >= 0; i--) step($sformatf("exr%0d", i), 4'(i), 1'b0);

    // Edge pulses.
    do_reset();
    step("e1", 4'b0000, 1'b0);
    step("e2", 4'b1100, 1'b0);
    step("e3", 4'b1100, 1'b0);
    step("e4", 4'b0000, 1'b0);
    step("e5", 4'b0000, 1'b0);

    // Saturating counter, then clear against a simultaneous hit.
    do_reset();
    for (int i = 0; i < 10; i++) step($sformatf("sat%0d", i), 4'b1100, 1'b0);
    step("clr", 4'b1100, 1'b1);
    step("clr_rel", 4'b1100, 1'b0);
    step("clr_idle", 4'b0000, 1'b1);

    // Random traffic with occasional clears.
    for (int i = 0; i < 40; i++)
      step($sformatf("rnd%0d", i), 4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));

    // Asynchronous reset mid-run with f=1 and a count of 5.
    do_reset();
    for (int i = 0; i < 5; i++) step($sformatf("pre%0d", i), 4'b1111, 1'b0);
    check("pre_cnt", 32'(hit_count), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async");
    model_reset();
    @(posedge clk);
    #1;
    check_zero("async_edge");
    #2;
    rst_n = 1'b1;
    step("post", 4'b0000, 1'b0);
    step("post2", 4'b0110, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
